// File: rtl/opb_register_bank.sv
// OPB slave bank of NUM_REGS registers, each bus-to-fabric (staged, committed on BE[3]) or fabric-to-bus (held snapshot).
// One-cycle acknowledge per access, no wait states; a select held through ACK is served every other cycle.
module opb_register_bank #(
   parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
   parameter logic [31:0] C_HIGHADDR   = 32'h0000_FFFF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter string       C_FAMILY     = "default",
   parameter int          NUM_REGS     = 4,
   parameter int          REG_WIDTH    = 32,
   parameter logic [15:0] DIR_MASK     = 16'h0000
) (
   input  logic                          OPB_Clk,
   input  logic                          OPB_Rst_n,
   input  logic [0:31]                   OPB_ABus,
   input  logic [0:3]                    OPB_BE,
   input  logic [0:31]                   OPB_DBus,
   input  logic                          OPB_RNW,
   input  logic                          OPB_select,
   input  logic                          OPB_seqAddr,
   output logic [0:31]                   Sl_DBus,
   output logic                          Sl_xferAck,
   output logic                          Sl_errAck,
   output logic                          Sl_retry,
   output logic                          Sl_toutSup,
   output logic [NUM_REGS*REG_WIDTH-1:0] user_data_out,
   output logic [NUM_REGS-1:0]           user_strobe,
   input  logic [NUM_REGS*REG_WIDTH-1:0] user_data_in
);

   localparam int    unused_width  = C_OPB_AWIDTH + C_OPB_DWIDTH;
   localparam string unused_family = C_FAMILY;

   typedef enum logic {S_IDLE, S_ACK} state_t;

   state_t                        state_q, state_d;
   logic                          ack_q, ack_d;
   logic [31:0]                   dbus_q, dbus_d;
   logic [REG_WIDTH-1:0]          stage_q [NUM_REGS];
   logic [REG_WIDTH-1:0]          stage_d [NUM_REGS];
   logic [REG_WIDTH-1:0]          snap_q  [NUM_REGS];
   logic [REG_WIDTH-1:0]          snap_d  [NUM_REGS];
   logic [NUM_REGS-1:0]           hold_q, hold_d;
   logic [NUM_REGS-1:0]           strobe_q, strobe_d;
   logic [NUM_REGS*REG_WIDTH-1:0] out_q, out_d;
   logic [NUM_REGS-1:0]           sel;

   logic [31:0]          addr, wdat, offset, bemask;
   logic [REG_WIDTH-1:0] wmask, wval;
   logic                 hit;
   logic                 unused_ok;

   // Bus bit 0 is the MSB, so plain assignment to [31:0] lands OPB bit 0 on bit 31.
   assign addr   = OPB_ABus;
   assign wdat   = OPB_DBus;
   assign offset = addr - C_BASEADDR;
   assign bemask = {{8{OPB_BE[0]}}, {8{OPB_BE[1]}}, {8{OPB_BE[2]}}, {8{OPB_BE[3]}}};
   assign wmask  = bemask[REG_WIDTH-1:0];
   assign wval   = wdat[REG_WIDTH-1:0];
   assign hit    = OPB_select && (state_q == S_IDLE) && (offset <= (C_HIGHADDR - C_BASEADDR));

   always_comb begin
      for (int i = 0; i < NUM_REGS; i++) begin
         sel[i] = hit && (offset[31:2] == 30'(i));
      end
   end

   always_comb begin
      state_d  = hit ? S_ACK : S_IDLE;
      ack_d    = hit;
      dbus_d   = '0;
      hold_d   = hold_q;
      strobe_d = '0;
      out_d    = out_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         stage_d[i] = stage_q[i];
         snap_d[i]  = snap_q[i];
         if (DIR_MASK[i]) begin
            if (sel[i] && OPB_RNW) begin
               dbus_d    = 32'(snap_q[i]);
               hold_d[i] = (hold_q[i] | OPB_BE[0]) & ~OPB_BE[3];
            end
            // Freeze on the edge that sets hold so the value just returned is the one kept.
            if (!hold_q[i] && !hold_d[i]) begin
               snap_d[i] = user_data_in[i*REG_WIDTH +: REG_WIDTH];
            end
         end else if (sel[i] && OPB_RNW) begin
            dbus_d = 32'(stage_q[i]);
         end else if (sel[i]) begin
            stage_d[i] = (stage_q[i] & ~wmask) | (wval & wmask);
            if (OPB_BE[3]) begin
               out_d[i*REG_WIDTH +: REG_WIDTH] = stage_d[i];
               strobe_d[i]                     = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
      if (!OPB_Rst_n) begin
         state_q  <= S_IDLE;
         ack_q    <= 1'b0;
         dbus_q   <= '0;
         hold_q   <= '0;
         strobe_q <= '0;
         out_q    <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            stage_q[i] <= '0;
            snap_q[i]  <= '0;
         end
      end else begin
         state_q  <= state_d;
         ack_q    <= ack_d;
         dbus_q   <= dbus_d;
         hold_q   <= hold_d;
         strobe_q <= strobe_d;
         out_q    <= out_d;
         for (int i = 0; i < NUM_REGS; i++) begin
            stage_q[i] <= stage_d[i];
            snap_q[i]  <= snap_d[i];
         end
      end
   end

   assign Sl_DBus       = dbus_q;
   assign Sl_xferAck    = ack_q;
   assign Sl_errAck     = 1'b0;
   assign Sl_retry      = 1'b0;
   assign Sl_toutSup    = 1'b0;
   assign user_data_out = out_q;
   assign user_strobe   = strobe_q;

   assign unused_ok = ^{OPB_seqAddr, offset[1:0], wdat, bemask};

endmodule

// File: tb/tb_opb_register_bank.sv
// Directed bench for opb_register_bank: a 32-bit bank (register 2 fabric-to-bus) and a 12-bit bank at 0x10000.
module tb_opb_register_bank;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic [0:31] abus   = '0;
   logic [0:31] dbus_w = '0;
   logic [0:3]  be     = '0;
   logic        rnw    = 1'b0;
   logic        sel    = 1'b0;
   logic        seq    = 1'b0;

   logic [0:31]  sl_dbus0, sl_dbus1;
   logic         ack0, ack1, err0, err1, rty0, rty1, tsup0, tsup1;
   logic [127:0] uout0;
   logic [127:0] udi0 = '1;
   logic [47:0]  uout1;
   logic [47:0]  udi1 = '0;
   logic [3:0]   stb0, stb1;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] u_at_sel;

   always #5 clk = ~clk;

   opb_register_bank #(
      .C_BASEADDR(32'h0000_0000), .C_HIGHADDR(32'h0000_FFFF),
      .NUM_REGS(4), .REG_WIDTH(32), .DIR_MASK(16'h0004)
   ) dut (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
      .Sl_DBus(sl_dbus0), .Sl_xferAck(ack0), .Sl_errAck(err0), .Sl_retry(rty0), .Sl_toutSup(tsup0),
      .user_data_out(uout0), .user_strobe(stb0), .user_data_in(udi0)
   );

   opb_register_bank #(
      .C_BASEADDR(32'h0001_0000), .C_HIGHADDR(32'h0001_FFFF),
      .NUM_REGS(4), .REG_WIDTH(12), .DIR_MASK(16'h0000)
   ) dut12 (
      .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
      .Sl_DBus(sl_dbus1), .Sl_xferAck(ack1), .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(tsup1),
      .user_data_out(uout1), .user_strobe(stb1), .user_data_in(udi1)
   );

   typedef struct {
      logic [31:0] addr;
      logic        rnw;
      logic [3:0]  be;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic [3:0]  exp_s0;
      logic [3:0]  exp_s1;
      int          uidx;
      logic [31:0] exp_u;
   } vec_t;

   vec_t vt [17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Slots 0-3: 32-bit bank, slots 4-7: 12-bit bank zero-extended.
   function automatic logic [31:0] uview(input int idx);
      if (idx < 4) return uout0[idx*32 +: 32];
      return 32'(uout1[(idx-4)*12 +: 12]);
   endfunction

   task automatic xfer(input logic [31:0] a, input logic r, input logic [3:0] b, input logic [31:0] d,
                       output logic [31:0] rd, output logic [3:0] s0, output logic [3:0] s1,
                       output int lat);
      @(negedge clk);
      abus = a; rnw = r; be = b; dbus_w = d; sel = 1'b1;
      u_at_sel = udi0[64 +: 32];
      lat = -1; rd = '0; s0 = '0; s1 = '0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         sel = 1'b0;
         if (ack0 | ack1) begin
            lat = k; rd = sl_dbus0 | sl_dbus1; s0 = stb0; s1 = stb1;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
      $fatal(1);
   end

   initial begin
      logic [31:0] rd, v;
      logic [3:0]  s0, s1;
      int          lat, n_ack, n_stb;

      vt[0]  = '{32'h0000_0004, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0,        4'b0010, 4'b0000, 1, 32'hDEADBEEF};
      vt[1]  = '{32'h0000_0004, 1'b1, 4'b1111, 32'h0,        32'hDEADBEEF, 4'b0000, 4'b0000, 1, 32'hDEADBEEF};
      vt[2]  = '{32'h0000_0000, 1'b0, 4'b1100, 32'h12340000, 32'h0,        4'b0000, 4'b0000, 0, 32'h0};
      vt[3]  = '{32'h0000_0000, 1'b1, 4'b1111, 32'h0,        32'h12340000, 4'b0000, 4'b0000, 0, 32'h0};
      vt[4]  = '{32'h0000_0000, 1'b0, 4'b0011, 32'h00005678, 32'h0,        4'b0001, 4'b0000, 0, 32'h12345678};
      vt[5]  = '{32'h0000_0000, 1'b1, 4'b1111, 32'h0,        32'h12345678, 4'b0000, 4'b0000, 0, 32'h12345678};
      vt[6]  = '{32'h0000_000C, 1'b0, 4'b0001, 32'h000000A5, 32'h0,        4'b1000, 4'b0000, 3, 32'h000000A5};
      vt[7]  = '{32'h0000_000C, 1'b0, 4'b1000, 32'h77000000, 32'h0,        4'b0000, 4'b0000, 3, 32'h000000A5};
      vt[8]  = '{32'h0000_000C, 1'b1, 4'b1111, 32'h0,        32'h770000A5, 4'b0000, 4'b0000, 3, 32'h000000A5};
      vt[9]  = '{32'h0000_0008, 1'b0, 4'b1111, 32'hAAAA5555, 32'h0,        4'b0000, 4'b0000, 2, 32'h0};
      vt[10] = '{32'h0001_0004, 1'b0, 4'b1111, 32'hFFFFFFFF, 32'h0,        4'b0000, 4'b0010, 5, 32'h00000FFF};
      vt[11] = '{32'h0001_0004, 1'b1, 4'b1111, 32'h0,        32'h00000FFF, 4'b0000, 4'b0000, 5, 32'h00000FFF};
      vt[12] = '{32'h0001_0000, 1'b0, 4'b0011, 32'h0000ABCD, 32'h0,        4'b0000, 4'b0001, 4, 32'h00000BCD};
      vt[13] = '{32'h0001_0010, 1'b0, 4'b1111, 32'hFFFFFFFF, 32'h0,        4'b0000, 4'b0000, 4, 32'h00000BCD};
      vt[14] = '{32'h0001_0010, 1'b1, 4'b1111, 32'h0,        32'h0,        4'b0000, 4'b0000, 5, 32'h00000FFF};
      vt[15] = '{32'h0001_0000, 1'b1, 4'b1111, 32'h0,        32'h00000BCD, 4'b0000, 4'b0000, 4, 32'h00000BCD};
      vt[16] = '{32'h0001_000C, 1'b1, 4'b1111, 32'h0,        32'h0,        4'b0000, 4'b0000, 7, 32'h0};

      // Reset with user_data_in all ones.
      #12;
      chk("rst_ack0",  32'(ack0), 32'h0);
      chk("rst_ack1",  32'(ack1), 32'h0);
      chk("rst_dbus0", sl_dbus0, 32'h0);
      chk("rst_dbus1", sl_dbus1, 32'h0);
      chk("rst_uout0", 32'(|uout0), 32'h0);
      chk("rst_uout1", 32'(|uout1), 32'h0);
      chk("rst_stb",   32'({stb0, stb1}), 32'h0);
      chk("tieoffs",   32'({err0, rty0, tsup0, err1, rty1, tsup1}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      xfer(32'h8, 1'b1, 4'b1111, 32'h0, rd, s0, s1, lat);
      chk("first_f2b_read", rd, 32'hFFFFFFFF);

      for (int i = 0; i < 17; i++) begin
         xfer(vt[i].addr, vt[i].rnw, vt[i].be, vt[i].wd, rd, s0, s1, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
         chk($sformatf("v%0d_dbus", i), rd, vt[i].exp_rd);
         chk($sformatf("v%0d_strobe32", i), 32'(s0), 32'(vt[i].exp_s0));
         chk($sformatf("v%0d_strobe12", i), 32'(s1), 32'(vt[i].exp_s1));
         chk($sformatf("v%0d_uout", i), uview(vt[i].uidx), vt[i].exp_u);
         @(negedge clk);
         chk($sformatf("v%0d_strobe_clear", i), 32'({stb0, stb1, ack0, ack1}), 32'h0);
      end

      // Two-stage read of an incrementing fabric value must return one coherent sample.
      udi0[64 +: 32] = 32'h1000_2000;
      fork
         begin
            repeat (40) begin
               @(posedge clk);
               #2 udi0[64 +: 32] = udi0[64 +: 32] + 32'h0001_0001;
            end
         end
         begin
            repeat (2) @(negedge clk);
            xfer(32'h8, 1'b1, 4'b1100, 32'h0, rd, s0, s1, lat);
            v = u_at_sel - 32'h0001_0001;
            chk("f2b_hi_read", rd, v);
            repeat (10) @(negedge clk);
            xfer(32'h8, 1'b1, 4'b0011, 32'h0, rd, s0, s1, lat);
            chk("f2b_lo_read", rd, v);
            repeat (3) @(negedge clk);
            xfer(32'h8, 1'b1, 4'b1111, 32'h0, rd, s0, s1, lat);
            chk("f2b_hold_released", rd, u_at_sel - 32'h0001_0001);
         end
      join

      // Select held for six cycles: three acks, three commits.
      @(negedge clk);
      abus = 32'h4; rnw = 1'b0; be = 4'b1111; dbus_w = 32'h0BADF00D; sel = 1'b1;
      n_ack = 0; n_stb = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ack0) n_ack++;
         if (stb0[1]) n_stb++;
         if (k == 5) sel = 1'b0;
      end
      chk("held_sel_acks", 32'(n_ack), 32'd3);
      chk("held_sel_strobes", 32'(n_stb), 32'd3);
      chk("held_sel_uout", uview(1), 32'h0BADF00D);

      // Reset asserted in the middle of the ACK cycle.
      @(negedge clk);
      abus = 32'h0; rnw = 1'b0; be = 4'b1111; dbus_w = 32'hCAFEF00D; sel = 1'b1;
      @(negedge clk);
      sel = 1'b0;
      chk("midack_ack_seen", 32'(ack0), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("midack_ack_drop", 32'(ack0), 32'h0);
      chk("midack_strobe", 32'(stb0), 32'h0);
      chk("midack_uout", 32'(|uout0), 32'h0);
      chk("midack_dbus", sl_dbus0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(32'h0, 1'b1, 4'b1111, 32'h0, rd, s0, s1, lat);
      chk("post_rst_stage0", rd, 32'h0);
      xfer(32'h4, 1'b1, 4'b1111, 32'h0, rd, s0, s1, lat);
      chk("post_rst_stage1", rd, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/opb_register_bank.md
# opb_register_bank

Parametrised bank of NUM_REGS software-accessible registers on the OPB slave bus, replacing single-register OPB shims with one decoder and one acknowledge path. Each register is either bus-to-fabric (PPC writes, user logic reads, atomic commit with one-cycle update strobe) or fabric-to-bus (user logic drives, PPC reads a tear-free snapshot), selected per register by DIR_MASK. The block runs entirely in the OPB clock domain; user logic is synchronous to OPB_Clk.

## Interface
- C_BASEADDR, 32'h00000000: first byte address of the bank.
- C_HIGHADDR, 32'h0000FFFF: last byte address decoded.
- C_OPB_AWIDTH, 32: bus address width (informational).
- C_OPB_DWIDTH, 32: bus data width (informational).
- C_FAMILY, "default": device family (informational).
- NUM_REGS, 4: registers in the bank, 1..16; register i at C_BASEADDR + 4*i.
- REG_WIDTH, 32: bits per register, 1..32, LSB-aligned in the bus word.
- DIR_MASK, 0: bit i = 1 makes register i fabric-to-bus; 0 makes it bus-to-fabric.
- OPB_Clk  in  1  sole clock.
- OPB_Rst_n  in  1  asynchronous, active-low reset.
- OPB_ABus  in  [0:31]  byte address.
- OPB_BE  in  [0:3]  byte enables; BE[0] is bits 31:24.
- OPB_DBus  in  [0:31]  write data; OPB_DBus[0] is register bit 31.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  transfer request.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data, zero except during acknowledge.
- Sl_xferAck  out  1  single-cycle acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_out  out  NUM_REGS*REG_WIDTH  committed bus-to-fabric values; register i at [i*REG_WIDTH +: REG_WIDTH].
- user_strobe  out  NUM_REGS  one-cycle pulse per register on commit.
- user_data_in  in  NUM_REGS*REG_WIDTH  fabric-to-bus values, same packing.

## Operation
- Decode: match = OPB_select and C_BASEADDR <= OPB_ABus <= C_HIGHADDR; index = (OPB_ABus - C_BASEADDR) >> 2.
- Any match with Sl_xferAck low produces an acknowledge on the next cycle; index >= NUM_REGS is acknowledged, reads 0, writes discarded.
- Bus-to-fabric write: enabled bytes go into staging[i]. If BE[3] is set, staging (including this write's bytes) commits to user_data_out[i], and user_strobe[i] pulses. BE[3] clear: staging only, no commit, no strobe.
- Bus-to-fabric read returns staging[i].
- Writes to fabric-to-bus registers are acknowledged and discarded.
- Fabric-to-bus snapshot[i] loads user_data_in[i] every cycle while hold[i] = 0.
- A read with BE[0] set sets hold[i]. A read with BE[3] set clears it, or a full-word read leaves it clear.
- Reads return snapshot[i]. The two-stage ROACH read (BE 1100 then 0011) therefore returns one coherent sample.
- Width: bits above REG_WIDTH read 0 and are dropped on write.
- States per access: IDLE -> ACK (one cycle) -> IDLE. In ACK, select is ignored, so a held select yields one ack per two cycles.

## Timing
- Reset (OPB_Rst_n low, asynchronous) sets all of the following to 0: Sl_xferAck, Sl_DBus, user_data_out, user_strobe, staging, snapshot, hold.
- Release of reset is synchronous to OPB_Clk.
- Reset asserted during ACK aborts the transfer: the ack drops immediately and there is no commit.
- Latency:
  - select to Sl_xferAck: 1 cycle.
  - write to user_data_out update and user_strobe: 1 cycle, coincident with Sl_xferAck.
  - user_data_in to snapshot: 1 cycle when not held.
- Sl_DBus is valid only in the Sl_xferAck cycle and is registered from staging or snapshot.
- Back-to-back commits to the same register produce one strobe each, on consecutive ack cycles. Commits to different registers are independent.

## Test plan
- Reset with user_data_in = all 1s: every output 0. After release, the first read of a fabric-to-bus register returns 32'hFFFFFFFF.
- Write 32'hDEADBEEF, BE 1111, to register 1: ack 1 cycle after select, user_data_out[1] = DEADBEEF with a single user_strobe[1] pulse in the same cycle, then read-back DEADBEEF.
- Write 32'h12340000 with BE 1100, then 32'h00005678 with BE 0011:
  - no strobe after the first write;
  - after the second, commit 12345678 with one strobe;
  - a read between the two writes returns 12340000.
- Fabric-to-bus register 2, user_data_in incrementing every cycle: a BE 1100 read then a BE 0011 read ten cycles later assemble a single sampled value; hold clears afterwards.
- REG_WIDTH = 12: write FFFFFFFF -> user_data_out = 12'hFFF, read-back 32'h00000FFF. A write to index NUM_REGS is acked, reads 0, and changes nothing.
- Select held high for 6 cycles: exactly 3 acks. Reset pulsed mid-ACK: ack drops asynchronously, no strobe, outputs 0.
